// File: rtl/comp1_rr_arbiter_if.sv
// comp1_rr_arbiter_if: requester-side and shared-channel stream signals of the round-robin arbiter
interface comp1_rr_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 32
);
  localparam int ID_W = $clog2(NUM_REQ);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_last;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      out_valid;
  logic [DATA_W-1:0]         out_data;
  logic                      out_last;
  logic                      out_ready;
  logic [ID_W-1:0]           grant_id;
  logic                      busy;
  modport master (
    output req_valid, req_data, req_last, out_ready,
    input  req_ready, out_valid, out_data, out_last, grant_id, busy
  );
  modport slave (
    input  req_valid, req_data, req_last, out_ready,
    output req_ready, out_valid, out_data, out_last, grant_id, busy
  );
endinterface

// File: rtl/comp1_rr_arbiter.sv
// comp1_rr_arbiter: packet-locked round-robin arbiter onto one valid/ready/last channel.
// Optional per-requester grant counters when COMP1_RR_ARBITER_STATS_EN is defined.
module comp1_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 32
) (
  input  logic clk,
  input  logic rst_n,
`ifdef COMP1_RR_ARBITER_STATS_EN
  input  logic                   stats_clr,
  output logic [NUM_REQ*16-1:0]  grant_cnt,
`endif
  comp1_rr_arbiter_if.slave bus
);
  localparam int ID_W = $clog2(NUM_REQ);
  typedef enum logic {IDLE, LOCK} state_t;
  state_t          state;
  logic [ID_W-1:0] grant_id, last_grant, win;
  logic            busy, lock, grab;
  // Scan from farthest to nearest so the first valid after last_grant wins.
  function automatic logic [ID_W-1:0] pick(input logic [NUM_REQ-1:0] v, input logic [ID_W-1:0] lg);
    logic [ID_W-1:0] idx;
    pick = lg;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = ID_W'((int'(lg) + k) % NUM_REQ);
      if (v[idx]) pick = idx;
    end
  endfunction
  assign win  = pick(bus.req_valid, last_grant);
  assign lock = state == LOCK;
  assign grab = !lock && |bus.req_valid;
  assign bus.out_valid = lock & bus.req_valid[grant_id];
  assign bus.out_last  = lock & bus.req_last[grant_id];
  assign bus.out_data  = lock ? bus.req_data[grant_id*DATA_W +: DATA_W] : '0;
  assign bus.req_ready = lock ? (NUM_REQ'(bus.out_ready) << grant_id) : '0;
  assign bus.grant_id  = grant_id;
  assign bus.busy      = busy;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state      <= IDLE;
      grant_id   <= '0;
      busy       <= 1'b0;
      last_grant <= ID_W'(NUM_REQ - 1);
    end else if (grab) begin
      state      <= LOCK;
      grant_id   <= win;
      busy       <= 1'b1;
      last_grant <= win;
    end else if (lock && bus.out_valid && bus.out_ready && bus.out_last) begin
      state <= IDLE;
      busy  <= 1'b0;
    end
`ifdef COMP1_RR_ARBITER_STATS_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) grant_cnt <= '0;
    else if (stats_clr) grant_cnt <= '0;
    else if (grab && grant_cnt[win*16 +: 16] != 16'hFFFF) grant_cnt[win*16 +: 16] <= grant_cnt[win*16 +: 16] + 16'd1;
`endif
endmodule

// File: tb/tb_comp1_rr_arbiter.sv
// tb_comp1_rr_arbiter: directed self-checking bench for comp1_rr_arbiter (NUM_REQ=4, DATA_W=32)
module tb_comp1_rr_arbiter;
  localparam int N = 4;
  localparam int W = 32;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  comp1_rr_arbiter_if #(.NUM_REQ(N), .DATA_W(W)) bus ();
`ifdef COMP1_RR_ARBITER_STATS_EN
  logic stats_clr = 1'b0;
  logic [N*16-1:0] grant_cnt;
`endif
  comp1_rr_arbiter #(.NUM_REQ(N), .DATA_W(W)) dut (
    .clk(clk),
    .rst_n(rst_n),
`ifdef COMP1_RR_ARBITER_STATS_EN
    .stats_clr(stats_clr),
    .grant_cnt(grant_cnt),
`endif
    .bus(bus)
  );
  int tests = 0;
  int fails = 0;
  logic [40:0] obs, exp_v;
  // busy, grant_id, out_valid, out_last, req_ready, out_data
  assign obs = {bus.busy, bus.grant_id, bus.out_valid, bus.out_last, bus.req_ready, bus.out_data};
  a_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (bus.out_valid && !bus.out_ready) |=> ($stable(bus.out_data) && $stable(bus.out_last)))
    else $error("held beat changed under back-pressure");
  task automatic cycle;
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input int i, input logic v, input logic [W-1:0] d, input logic l);
    bus.req_valid[i]       = v;
    bus.req_data[i*W +: W] = d;
    bus.req_last[i]        = l;
  endtask
  task automatic do_reset;
    bus.req_valid = '0;
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    cycle();
  endtask
  task automatic test_reset;
    rst_n = 1'b0;
    bus.req_valid = 4'b1111;
    bus.req_last = '0;
    bus.req_data = '0;
    bus.out_ready = 1'b1;
    #1;
    exp_v = {1'b0, 2'd0, 1'b0, 1'b0, 4'b0000, 32'h0};
    if (obs !== exp_v) begin fails++; $display("FAIL reset got %h exp %h", obs, exp_v); end
    tests++;
    cycle();
    if (obs !== exp_v) begin fails++; $display("FAIL reset_hold got %h exp %h", obs, exp_v); end
    tests++;
    bus.req_valid = '0;
    rst_n = 1'b1;
    cycle();
  endtask
  task automatic test_single_req;
    drive(2, 1'b1, 32'hA0, 1'b0);
    bus.out_ready = 1'b1;
    #1;
    exp_v = {1'b0, 2'd0, 1'b0, 1'b0, 4'b0000, 32'h0};
    if (obs !== exp_v) begin fails++; $display("FAIL t2_idle got %h exp %h", obs, exp_v); end
    tests++;
    cycle();
    for (int k = 0; k < 3; k++) begin
      #1;
      exp_v = {1'b1, 2'd2, 1'b1, k == 2, 4'b0100, 32'(32'hA0 + k)};
      if (obs !== exp_v) begin fails++; $display("FAIL t2_beat%0d got %h exp %h", k, obs, exp_v); end
      tests++;
      cycle();
      if (k < 2) drive(2, 1'b1, 32'(32'hA1 + k), k == 1);
      else drive(2, 1'b0, 32'h0, 1'b0);
    end
    #1;
    exp_v = {1'b0, 2'd2, 1'b0, 1'b0, 4'b0000, 32'h0};
    if (obs !== exp_v) begin fails++; $display("FAIL t2_done got %h exp %h", obs, exp_v); end
    tests++;
  endtask
  task automatic test_round_robin;
    do_reset();
    for (int i = 0; i < N; i++) drive(i, 1'b1, 32'(32'hB0 + i), 1'b1);
    for (int r = 0; r < 5; r++) begin
      cycle();
      exp_v = {1'b1, 2'(r % N), 1'b1, 1'b1, 4'(4'b0001 << (r % N)), 32'(32'hB0 + r % N)};
      if (obs !== exp_v) begin fails++; $display("FAIL t3_grant%0d got %h exp %h", r, obs, exp_v); end
      tests++;
      cycle();
      exp_v = {1'b0, 2'(r % N), 1'b0, 1'b0, 4'b0000, 32'h0};
      if (obs !== exp_v) begin fails++; $display("FAIL t3_gap%0d got %h exp %h", r, obs, exp_v); end
      tests++;
    end
    bus.req_valid = '0;
  endtask
  task automatic test_back_pressure;
    drive(1, 1'b1, 32'hC0, 1'b0);
    bus.out_ready = 1'b1;
    cycle();
    exp_v = {1'b1, 2'd1, 1'b1, 1'b0, 4'b0010, 32'hC0};
    if (obs !== exp_v) begin fails++; $display("FAIL t4_c0 got %h exp %h", obs, exp_v); end
    tests++;
    cycle();
    drive(1, 1'b1, 32'hC1, 1'b0);
    bus.out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      exp_v = {1'b1, 2'd1, 1'b1, 1'b0, 4'b0000, 32'hC1};
      if (obs !== exp_v) begin fails++; $display("FAIL t4_hold%0d got %h exp %h", k, obs, exp_v); end
      tests++;
      cycle();
    end
    bus.out_ready = 1'b1;
    #1;
    exp_v = {1'b1, 2'd1, 1'b1, 1'b0, 4'b0010, 32'hC1};
    if (obs !== exp_v) begin fails++; $display("FAIL t4_resume got %h exp %h", obs, exp_v); end
    tests++;
    cycle();
    drive(1, 1'b1, 32'hC2, 1'b1);
    #1;
    exp_v = {1'b1, 2'd1, 1'b1, 1'b1, 4'b0010, 32'hC2};
    if (obs !== exp_v) begin fails++; $display("FAIL t4_last got %h exp %h", obs, exp_v); end
    tests++;
    cycle();
    drive(1, 1'b0, 32'h0, 1'b0);
    #1;
    exp_v = {1'b0, 2'd1, 1'b0, 1'b0, 4'b0000, 32'h0};
    if (obs !== exp_v) begin fails++; $display("FAIL t4_done got %h exp %h", obs, exp_v); end
    tests++;
  endtask
  task automatic test_late_request;
    drive(1, 1'b1, 32'hD0, 1'b0);
    cycle();
    exp_v = {1'b1, 2'd1, 1'b1, 1'b0, 4'b0010, 32'hD0};
    if (obs !== exp_v) begin fails++; $display("FAIL t5_d0 got %h exp %h", obs, exp_v); end
    tests++;
    drive(0, 1'b1, 32'hE0, 1'b1);
    #1;
    if (obs !== exp_v) begin fails++; $display("FAIL t5_hold got %h exp %h", obs, exp_v); end
    tests++;
    cycle();
    drive(1, 1'b1, 32'hD1, 1'b1);
    #1;
    exp_v = {1'b1, 2'd1, 1'b1, 1'b1, 4'b0010, 32'hD1};
    if (obs !== exp_v) begin fails++; $display("FAIL t5_d1 got %h exp %h", obs, exp_v); end
    tests++;
    cycle();
    drive(1, 1'b0, 32'h0, 1'b0);
    #1;
    exp_v = {1'b0, 2'd1, 1'b0, 1'b0, 4'b0000, 32'h0};
    if (obs !== exp_v) begin fails++; $display("FAIL t5_gap got %h exp %h", obs, exp_v); end
    tests++;
    cycle();
    exp_v = {1'b1, 2'd0, 1'b1, 1'b1, 4'b0001, 32'hE0};
    if (obs !== exp_v) begin fails++; $display("FAIL t5_next got %h exp %h", obs, exp_v); end
    tests++;
    cycle();
    drive(0, 1'b0, 32'h0, 1'b0);
    #1;
    exp_v = {1'b0, 2'd0, 1'b0, 1'b0, 4'b0000, 32'h0};
    if (obs !== exp_v) begin fails++; $display("FAIL t5_done got %h exp %h", obs, exp_v); end
    tests++;
  endtask
  task automatic test_reset_mid;
    drive(1, 1'b1, 32'hF0, 1'b0);
    cycle();
    exp_v = {1'b1, 2'd1, 1'b1, 1'b0, 4'b0010, 32'hF0};
    if (obs !== exp_v) begin fails++; $display("FAIL t6_f0 got %h exp %h", obs, exp_v); end
    tests++;
    cycle();
    drive(1, 1'b1, 32'hF1, 1'b0);
    #1;
    exp_v = {1'b1, 2'd1, 1'b1, 1'b0, 4'b0010, 32'hF1};
    if (obs !== exp_v) begin fails++; $display("FAIL t6_f1 got %h exp %h", obs, exp_v); end
    tests++;
    rst_n = 1'b0;
    drive(2, 1'b1, 32'h70, 1'b1);
    #1;
    exp_v = {1'b0, 2'd0, 1'b0, 1'b0, 4'b0000, 32'h0};
    if (obs !== exp_v) begin fails++; $display("FAIL t6_reset got %h exp %h", obs, exp_v); end
    tests++;
    cycle();
    rst_n = 1'b1;
    drive(1, 1'b1, 32'hF0, 1'b0);
    cycle();
    exp_v = {1'b1, 2'd1, 1'b1, 1'b0, 4'b0010, 32'hF0};
    if (obs !== exp_v) begin fails++; $display("FAIL t6_regrant got %h exp %h", obs, exp_v); end
    tests++;
    do_reset();
  endtask
`ifdef COMP1_RR_ARBITER_STATS_EN
  task automatic test_stats;
    do_reset();
    if (grant_cnt !== 64'h0) begin fails++; $display("FAIL st_reset got %h exp %h", grant_cnt, 64'h0); end
    tests++;
    drive(3, 1'b1, 32'h33, 1'b1);
    for (int k = 0; k < 3; k++) begin
      cycle();
      cycle();
    end
    drive(3, 1'b0, 32'h0, 1'b0);
    #1;
    if (grant_cnt !== {16'd3, 48'h0}) begin fails++; $display("FAIL st_count got %h exp %h", grant_cnt, {16'd3, 48'h0}); end
    tests++;
    stats_clr = 1'b1;
    cycle();
    stats_clr = 1'b0;
    if (grant_cnt !== 64'h0) begin fails++; $display("FAIL st_clear got %h exp %h", grant_cnt, 64'h0); end
    tests++;
  endtask
`endif
  initial begin
    test_reset();
    test_single_req();
    test_round_robin();
    test_back_pressure();
    test_late_request();
    test_reset_mid();
`ifdef COMP1_RR_ARBITER_STATS_EN
    test_stats();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
